// File: rtl/mem_1r1w_synth.sv
// Flop-array RAM: one synchronous write port, one combinational read port.
// Ports: w_clk_i/w_reset_i(async, low), w_v_i/w_addr_i/w_data_i, r_v_i/r_addr_i -> r_data_o.
module mem_1r1w_synth #(
  parameter int width_p = 32,
  parameter int els_p = 16,
  parameter int read_write_same_addr_p = 0,
  parameter int harden_p = 0,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1,
  // width_p=0 still needs a legal vector; the output is tied to zero then
  localparam int dw_lp = (width_p > 0) ? width_p : 1
) (
  input  logic                     w_clk_i,
  input  logic                     w_reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [dw_lp-1:0]         w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [dw_lp-1:0]         r_data_o
);

  localparam logic [addr_width_lp:0] els_lp =
    (addr_width_lp+1)'(els_p);

  logic [dw_lp-1:0] mem_q [els_p];
  logic [dw_lp-1:0] mem_d [els_p];
  logic             w_en;
  logic             r_in;

  always_comb begin
    w_en  = w_v_i & ({1'b0, w_addr_i} < els_lp);
    mem_d = mem_q;
    if (w_en) begin
      mem_d[w_addr_i] = w_data_i;
    end
  end

  always_ff @(posedge w_clk_i or negedge w_reset_i) begin
    if (!w_reset_i) begin
      for (int i = 0; i < els_p; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // no write-through: a same-cycle write shows up only after the edge
  always_comb begin
    r_in     = ({1'b0, r_addr_i} < els_lp);
    r_data_o = '0;
    if (r_in && (width_p > 0)) begin
      r_data_o = mem_q[r_addr_i];
    end
  end

  // r_v_i and the mode/hardening knobs have no functional effect
  logic unused_sigs;
  assign unused_sigs = r_v_i
    ^ (read_write_same_addr_p != 0)
    ^ (harden_p != 0);

endmodule

// File: tb/tb_mem_1r1w_synth.sv
// Bench for mem_1r1w_synth: two instances (16 entries / 12 entries)
// share stimulus and are checked against an array reference model.
module tb_mem_1r1w_synth;

  logic        clk;
  logic        rst_n;
  logic        wv;
  logic [3:0]  wa;
  logic [31:0] wd;
  logic        rv;
  logic [3:0]  ra;
  logic [31:0] rd_a;
  logic [31:0] rd_b;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ma [16];
  logic [31:0] mb [12];

  mem_1r1w_synth #(
    .width_p(32),
    .els_p(16),
    .read_write_same_addr_p(0)
  ) dut_a (
    .w_clk_i(clk),
    .w_reset_i(rst_n),
    .w_v_i(wv),
    .w_addr_i(wa),
    .w_data_i(wd),
    .r_v_i(rv),
    .r_addr_i(ra),
    .r_data_o(rd_a)
  );

  mem_1r1w_synth #(
    .width_p(32),
    .els_p(12),
    .read_write_same_addr_p(1)
  ) dut_b (
    .w_clk_i(clk),
    .w_reset_i(rst_n),
    .w_v_i(wv),
    .w_addr_i(wa),
    .w_data_i(wd),
    .r_v_i(rv),
    .r_addr_i(ra),
    .r_data_o(rd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: a write lands at the edge only out of reset and in range
  always @(posedge clk) begin
    if (rst_n === 1'b1 && wv === 1'b1) begin
      ma[wa] = wd;
      if (wa < 12) mb[wa] = wd;
    end
  end

  function automatic logic [31:0] exp_a(logic [3:0] a);
    return ma[a];
  endfunction

  function automatic logic [31:0] exp_b(logic [3:0] a);
    return (a < 12) ? mb[a] : 32'h0;
  endfunction

  task automatic clr_model();
    for (int i = 0; i < 16; i++) ma[i] = '0;
    for (int i = 0; i < 12; i++) mb[i] = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag);
    logic [31:0] ea;
    logic [31:0] eb;
    #1;
    ea = exp_a(ra);
    eb = exp_b(ra);
    n_vec++;
    assert (rd_a === ea) else begin
      n_err++;
      $error("FAIL %s a addr=%0d got=%h exp=%h",
             tag, ra, rd_a, ea);
    end
    n_vec++;
    assert (rd_b === eb) else begin
      n_err++;
      $error("FAIL %s b addr=%0d got=%h exp=%h",
             tag, ra, rd_b, eb);
    end
  endtask

  task automatic sweep(string tag);
    for (int i = 0; i < 16; i++) begin
      ra = 4'(i);
      chk(tag);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wv = 1'b1;
    wa = 4'd3;
    wd = 32'hDEADBEEF;
    rv = 1'b0;
    ra = '0;
    clr_model();

    // reset holds off writes
    repeat (3) tick();
    sweep("reset");
    wv = 1'b0;
    rst_n = 1'b1;

    // fill and read back
    for (int i = 0; i < 16; i++) begin
      wv = 1'b1;
      wa = 4'(i);
      wd = 32'hA0 + i;
      tick();
    end
    wv = 1'b0;
    sweep("wr_rd");

    // same address read/write: old before edge, new after
    wv = 1'b1; wa = 4'd5; wd = 32'h11;
    tick();
    wd = 32'h22;
    ra = 4'd5;
    chk("same_pre");
    tick();
    wv = 1'b0;
    chk("same_post");

    // out-of-range write on the 12-entry array
    wv = 1'b1; wa = 4'd13; wd = 32'h55;
    tick();
    wv = 1'b0;
    sweep("oor_keep");
    ra = 4'd14;
    chk("oor_rd");

    // fill, then reset pulse between edges
    for (int i = 0; i < 16; i++) begin
      wv = 1'b1;
      wa = 4'(i);
      wd = 32'hFFFFFFFF;
      tick();
    end
    wv = 1'b0;
    ra = 4'd7;
    chk("fill");
    rst_n = 1'b0;
    clr_model();
    chk("mid_rst");
    ra = 4'd15;
    chk("mid_rst");
    rst_n = 1'b1;
    wv = 1'b1; wa = 4'd2; wd = 32'h7;
    tick();
    wv = 1'b0;
    sweep("post_rst");

    // reset held across a write edge drops that write
    wv = 1'b1; wa = 4'd4; wd = 32'h99;
    tick();
    #3;
    rst_n = 1'b0;
    clr_model();
    tick();
    rst_n = 1'b1;
    wv = 1'b0;
    ra = 4'd4;
    chk("rst_edge");
    wv = 1'b1; wa = 4'd2; wd = 32'h7;
    tick();
    wv = 1'b0;

    // w_v_i low: nothing changes
    for (int i = 0; i < 10; i++) begin
      wa = 4'($urandom_range(0, 15));
      wd = $urandom;
      tick();
    end
    sweep("wv_gate");
    ra = 4'd2;
    rv = 1'b1;
    chk("rv_on");
    rv = 1'b0;
    chk("rv_off");

    // random traffic with occasional reset pulses
    for (int i = 0; i < 300; i++) begin
      wv = 1'($urandom);
      wa = 4'($urandom);
      wd = $urandom;
      rv = 1'($urandom);
      ra = $urandom_range(0, 3) == 0 ? wa : 4'($urandom);
      chk("rnd_pre");
      tick();
      chk("rnd_post");
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        clr_model();
        chk("rnd_rst");
        rst_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
